// File: rtl/cpu_io_bridge_pkg.sv
// Shared decode constants and read-return select encoding for the CPU I/O bridge.
package cpu_io_bridge_pkg;

   localparam logic [1:0] IO_TAG      = 2'b11;
   localparam logic [2:0] IO_RX_TX    = 3'h0;
   localparam logic [2:0] IO_CLK_STOP = 3'h4;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_RX,
      SEL_CNT0,
      SEL_CNT1,
      SEL_CNT2,
      SEL_CNT3
   } sel_t;

   // Unmapped I/O offsets fall back to SEL_RX with a zero byte latched alongside.
   function automatic sel_t decode_sel(input logic io, input logic [2:0] off);
      sel_t s;
      if (!io) begin
         s = SEL_RAM;
      end else begin
         case (off)
            3'h4:    s = SEL_CNT0;
            3'h5:    s = SEL_CNT1;
            3'h6:    s = SEL_CNT2;
            3'h7:    s = SEL_CNT3;
            default: s = SEL_RX;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/cpu_io_bridge_if.sv
// Bus bundle between the CPU/RAM/UART environment (master) and the bridge (slave).
interface cpu_io_bridge_if;

   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        program_stop;
   logic        overflow_err;

   modport master (
      output cpu_a, cpu_dout, cpu_wr, ram_din, rx_data, rx_valid, tx_ready,
      input  cpu_din, io_buffer_full, ram_a, ram_dout, ram_we, rx_pop,
             tx_data, tx_valid, program_stop, overflow_err
   );

   modport slave (
      input  cpu_a, cpu_dout, cpu_wr, ram_din, rx_data, rx_valid, tx_ready,
      output cpu_din, io_buffer_full, ram_a, ram_dout, ram_we, rx_pop,
             tx_data, tx_valid, program_stop, overflow_err
   );

endinterface

// File: rtl/io_tx_fifo.sv
// Circular byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module io_tx_fifo #(
   parameter int FIFO_AW = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       dout,
   output logic [FIFO_AW:0] count,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = count[FIFO_AW];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_io_bridge.sv
// Splits CPU accesses between RAM and the I/O page: UART TX/RX, cycle counter with
// coherent snapshot, and program-stop sequencing once queued output has drained.
module cpu_io_bridge
   import cpu_io_bridge_pkg::*;
#(
   parameter int FIFO_AW = 3,
   parameter int CNT_W   = 32
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           rdy_in,
   cpu_io_bridge_if.slave bus
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             io;
   logic [2:0]       io_reg;
   logic             stop_wr;
   logic             push;
   logic             pop;
   logic [7:0]       push_data;
   logic [FIFO_AW:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             unused_addr;

   logic             rd_q;
   logic             hold_q;
   sel_t             sel_q;
   logic [7:0]       rx_q;
   logic [7:0]       last_din;
   logic [7:0]       live_din;
   logic [7:0]       din_out;
   logic             rx_pop_q;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] snapshot;
   logic [31:0]      snap_w;
   logic             stop_pending;
   logic             stop_q;
   logic             overflow_q;
   logic             full_q;

   assign io          = (bus.cpu_a[17:16] == IO_TAG);
   assign io_reg      = bus.cpu_a[2:0];
   assign unused_addr = ^bus.cpu_a[31:18];

   assign bus.ram_a    = bus.cpu_a[16:0];
   assign bus.ram_dout = bus.cpu_dout;
   assign bus.ram_we   = bus.cpu_wr & ~io & rdy_in;

   assign stop_wr   = rdy_in & bus.cpu_wr & io & ~stop_pending & (io_reg == IO_CLK_STOP);
   assign push      = stop_wr | (rdy_in & bus.cpu_wr & io & ~stop_pending &
                                 (io_reg == IO_RX_TX) & (bus.cpu_dout != 8'h00));
   assign push_data = stop_wr ? 8'h00 : bus.cpu_dout;
   assign pop       = ~fifo_empty & bus.tx_ready;

   io_tx_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .dout  (bus.tx_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.tx_valid = ~fifo_empty;
   assign snap_w       = 32'(snapshot);

   // CNT0 reads come from the snapshot, which captured the counter on that same edge.
   always_comb begin
      live_din = 8'h00;
      if (rd_q) begin
         case (sel_q)
            SEL_RAM:  live_din = bus.ram_din;
            SEL_RX:   live_din = rx_q;
            SEL_CNT0: live_din = snap_w[7:0];
            SEL_CNT1: live_din = snap_w[15:8];
            SEL_CNT2: live_din = snap_w[23:16];
            SEL_CNT3: live_din = snap_w[31:24];
            default:  live_din = 8'h00;
         endcase
      end
   end

   assign din_out = hold_q ? last_din : live_din;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_q         <= 1'b0;
         hold_q       <= 1'b0;
         sel_q        <= SEL_RAM;
         rx_q         <= 8'h00;
         last_din     <= 8'h00;
         rx_pop_q     <= 1'b0;
         counter      <= '0;
         snapshot     <= '0;
         stop_pending <= 1'b0;
         stop_q       <= 1'b0;
         overflow_q   <= 1'b0;
         full_q       <= 1'b0;
      end else begin
         hold_q   <= ~rdy_in;
         last_din <= din_out;
         rx_pop_q <= rdy_in & ~bus.cpu_wr & io & (io_reg == IO_RX_TX) & bus.rx_valid;
         full_q   <= (int'(fifo_count) >= DEPTH - 2);
         if (push & fifo_full & ~pop)                 overflow_q   <= 1'b1;
         if (stop_pending & fifo_empty & ~push)       stop_q       <= 1'b1;
         if (stop_wr)                                 stop_pending <= 1'b1;
         if (rdy_in) begin
            counter <= counter + CNT_ONE;
            rd_q    <= ~bus.cpu_wr;
            if (!bus.cpu_wr) begin
               sel_q <= decode_sel(io, io_reg);
               rx_q  <= (io & (io_reg == IO_RX_TX) & bus.rx_valid) ? bus.rx_data : 8'h00;
               if (io & (io_reg == IO_CLK_STOP)) snapshot <= counter;
            end
         end
      end
   end

   assign bus.cpu_din        = din_out;
   assign bus.rx_pop         = rx_pop_q;
   assign bus.io_buffer_full = full_q;
   assign bus.program_stop   = stop_q;
   assign bus.overflow_err   = overflow_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed plus randomized bench for cpu_io_bridge, checked against a queue-based model.
module tb_cpu_io_bridge;
   import cpu_io_bridge_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b0;

   cpu_io_bridge_if bus();

   cpu_io_bridge #(.FIFO_AW(3), .CNT_W(32)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   // Behavioural RAM with registered read (old data on a same-cycle write).
   logic [7:0] ram_mem [0:131071];
   bit         ram_ready = 1'b0;
   always @(posedge clk_in) begin
      if (!ram_ready) begin
         for (int i = 0; i < 131072; i++) ram_mem[i] <= 8'h00;
         bus.ram_din <= 8'h00;
         ram_ready   <= 1'b1;
      end else begin
         bus.ram_din <= ram_mem[bus.ram_a];
         if (bus.ram_we) ram_mem[bus.ram_a] <= bus.ram_dout;
      end
   end

   bit [7:0]  ref_q[$];
   bit [7:0]  ref_ram [bit [16:0]];
   bit [31:0] ref_cnt;
   bit [31:0] ref_snap;
   bit        ref_stop_pend;
   bit        ref_stopped;
   bit        ref_ovf;
   bit        ref_full;
   bit        ref_rx_pop;
   bit        din_chk;
   bit [7:0]  exp_din;
   int        errors = 0;
   int        checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [7:0] ram_lookup(input bit [16:0] a);
      return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
   endfunction

   task automatic model_reset();
      ref_q.delete();
      ref_cnt       = 0;
      ref_snap      = 0;
      ref_stop_pend = 0;
      ref_stopped   = 0;
      ref_ovf       = 0;
      ref_full      = 0;
      ref_rx_pop    = 0;
      din_chk       = 0;
      exp_din       = 0;
   endtask

   // Advances the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      int       sz;
      bit       is_io, pop_ev, push_ev, stop_wr;
      bit [2:0] off;
      bit [7:0] push_val;
      sz       = ref_q.size();
      is_io    = (bus.cpu_a[17:16] == 2'b11);
      off      = bus.cpu_a[2:0];
      pop_ev   = bus.tx_ready && (sz != 0);
      push_ev  = 0;
      stop_wr  = 0;
      push_val = 0;
      if (rdy_in && bus.cpu_wr && is_io && !ref_stop_pend) begin
         if (off == 3'd0 && bus.cpu_dout != 8'h00) begin
            push_ev  = 1;
            push_val = bus.cpu_dout;
         end else if (off == 3'd4) begin
            push_ev = 1;
            stop_wr = 1;
         end
      end
      if (ref_stop_pend && sz == 0 && !push_ev) ref_stopped = 1;
      ref_full = (sz >= 6);
      if (pop_ev) void'(ref_q.pop_front());
      if (push_ev) begin
         if (sz == 8 && !pop_ev) ref_ovf = 1;
         else ref_q.push_back(push_val);
      end
      if (stop_wr) ref_stop_pend = 1;
      ref_rx_pop = 0;
      if (rdy_in) begin
         if (!bus.cpu_wr) begin
            din_chk = 1;
            if (!is_io) begin
               exp_din = ram_lookup(bus.cpu_a[16:0]);
            end else begin
               case (off)
                  3'd0: begin
                     exp_din    = bus.rx_valid ? bus.rx_data : 8'h00;
                     ref_rx_pop = bus.rx_valid;
                  end
                  3'd4: begin
                     exp_din  = ref_cnt[7:0];
                     ref_snap = ref_cnt;
                  end
                  3'd5:    exp_din = ref_snap[15:8];
                  3'd6:    exp_din = ref_snap[23:16];
                  3'd7:    exp_din = ref_snap[31:24];
                  default: exp_din = 8'h00;
               endcase
            end
         end else begin
            din_chk = 0;
            if (!is_io) ref_ram[bus.cpu_a[16:0]] = bus.cpu_dout;
         end
         ref_cnt++;
      end
   endtask

   task automatic check_output();
      check("tx_valid", 32'(bus.tx_valid), 32'(ref_q.size() != 0));
      if (ref_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(ref_q[0]));
      check("io_buffer_full", 32'(bus.io_buffer_full), 32'(ref_full));
      check("overflow_err", 32'(bus.overflow_err), 32'(ref_ovf));
      check("program_stop", 32'(bus.program_stop), 32'(ref_stopped));
      check("rx_pop", 32'(bus.rx_pop), 32'(ref_rx_pop));
      if (din_chk) check("cpu_din", 32'(bus.cpu_din), 32'(exp_din));
   endtask

   task automatic check_reset_state();
      check("rst_cpu_din", 32'(bus.cpu_din), 32'h0);
      check("rst_rx_pop", 32'(bus.rx_pop), 32'h0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("rst_io_buffer_full", 32'(bus.io_buffer_full), 32'h0);
      check("rst_program_stop", 32'(bus.program_stop), 32'h0);
      check("rst_overflow_err", 32'(bus.overflow_err), 32'h0);
   endtask

   task automatic apply_stimulus(input bit rdy, input bit [31:0] a, input bit wr,
                                 input bit [7:0] d, input bit txr);
      rdy_in       = rdy;
      bus.cpu_a    = a;
      bus.cpu_wr   = wr;
      bus.cpu_dout = d;
      bus.tx_ready = txr;
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
      #1;
      check("ram_we", 32'(bus.ram_we), 32'(wr && (a[17:16] != 2'b11) && rdy));
      model_edge();
      @(posedge clk_in);
      #1;
      check_output();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      bus.cpu_a    = 32'h0;
      bus.cpu_dout = 8'h00;
      bus.cpu_wr   = 1'b0;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_state();
      rst_in = 1'b1;

      // RAM round trip and a handful of random RAM accesses
      apply_stimulus(1, 32'h0000_0123, 1, 8'h5A, 0);
      check("ram_a", 32'(bus.ram_a), 32'h00123);
      check("ram_dout", 32'(bus.ram_dout), 32'h5A);
      apply_stimulus(1, 32'h0000_0123, 0, 8'h00, 0);
      for (int i = 0; i < 24; i++)
         apply_stimulus(1, 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom), 0);

      // TX with the UART stalled; the zero byte must not enqueue
      apply_stimulus(1, 32'h0003_0000, 1, 8'h48, 0);
      apply_stimulus(1, 32'h0003_0000, 1, 8'h00, 0);
      apply_stimulus(1, 32'h0003_0000, 1, 8'h69, 0);
      repeat (10) apply_stimulus(1, 32'h0000_0000, 0, 8'h00, 0);
      repeat (4)  apply_stimulus(1, 32'h0000_0000, 0, 8'h00, 1);

      // Almost-full flag, fill to full, then overflow
      for (int i = 0; i < 6; i++) apply_stimulus(1, 32'h0003_0000, 1, 8'($urandom_range(1, 255)), 0);
      apply_stimulus(1, 32'h0000_0010, 0, 8'h00, 0);
      check("almost_full_after_6", 32'(bus.io_buffer_full), 32'h1);
      for (int i = 0; i < 3; i++) apply_stimulus(1, 32'h0003_0000, 1, 8'($urandom_range(1, 255)), 0);
      check("overflow_after_9", 32'(bus.overflow_err), 32'h1);
      repeat (10) apply_stimulus(1, 32'h0000_0010, 0, 8'h00, 1);

      // Randomized mixed traffic; stop writes are kept out of this phase
      for (int i = 0; i < 400; i++) begin
         bit        wr, io, rdy;
         bit [2:0]  off;
         bit [31:0] a;
         rdy = ($urandom_range(0, 3) != 0);
         wr  = 1'($urandom_range(0, 1));
         io  = 1'($urandom_range(0, 1));
         off = 3'($urandom_range(0, 7));
         if (wr && io && off == IO_CLK_STOP) off = IO_RX_TX;
         a = io ? (32'h0003_0000 | 32'(off)) : 32'($urandom_range(0, 31));
         a = a | ($urandom & 32'hFFFC_0000);
         apply_stimulus(rdy, a, wr, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                        1'($urandom_range(0, 1)));
      end

      // Counter snapshot reads, hold under rdy low, and a frozen counter
      for (int k = 4; k < 8; k++) apply_stimulus(1, 32'h0003_0000 + 32'(k), 0, 8'h00, 1);
      repeat (5) apply_stimulus(0, 32'h0003_0004, 0, 8'h00, 1);
      for (int k = 4; k < 8; k++) apply_stimulus(1, 32'h0003_0000 + 32'(k), 0, 8'h00, 1);

      // Asynchronous reset in the middle of a drain
      for (int i = 0; i < 4; i++) apply_stimulus(1, 32'h0003_0000, 1, 8'($urandom_range(1, 255)), 0);
      bus.tx_ready = 1'b1;
      #3;
      rst_in = 1'b0;
      #1;
      check("async_tx_valid", 32'(bus.tx_valid), 32'h0);
      check_reset_state();
      model_reset();
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      apply_stimulus(1, 32'h0003_0004, 0, 8'h00, 0);
      check("counter_after_reset", 32'(bus.cpu_din), 32'h0);
      apply_stimulus(1, 32'h0003_0000, 1, 8'hA5, 0);

      // Program stop once queued bytes and the stop marker are drained
      for (int i = 0; i < 2; i++) apply_stimulus(1, 32'h0003_0000, 1, 8'($urandom_range(1, 255)), 0);
      apply_stimulus(1, 32'h0003_0004, 1, 8'h00, 0);
      apply_stimulus(1, 32'h0003_0000, 1, 8'h77, 0);
      apply_stimulus(1, 32'h0003_0004, 1, 8'h00, 0);
      repeat (8) apply_stimulus(1, 32'h0000_0020, 0, 8'h00, 1);
      check("program_stop_final", 32'(bus.program_stop), 32'h1);
      apply_stimulus(1, 32'h0003_0000, 1, 8'h55, 1);
      check("write_after_stop", 32'(bus.tx_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
